m6809_core_wordseq: RTL
=======================

M6809_CORE_WORDSEQ -- requirements
Module: m6809_core_wordseq

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on clk rising edge.
REQ-003 start  in  1  request to execute one 16-bit operation; sampled only in IDLE.
REQ-004 op  in  4  opcode low nibble, 6809 encoding; captured on accepted start.
REQ-005 op6, page2, page3  in  1 each  disambiguation and page bits; captured with op.
REQ-006 ea  in  16  effective address of memory operand; captured on accepted start.
REQ-007 reg_in  in  16  register operand (LHS); captured on accepted start.
REQ-008 mem_req  out  1  byte-transfer request.
REQ-009 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-010 mem_addr  out  16  byte address; valid while mem_req.
REQ-011 mem_wdata  out  8  write byte; valid while mem_req and mem_we.
REQ-012 mem_rdata  in  8  read byte; valid when mem_ack.
REQ-013 mem_ack  in  1  transfer complete on this edge.
REQ-014 alu_in_a / alu_in_b  out  16 each  operands to the 16-bit ALU.
REQ-015 alu_op, alu_op6, alu_page2, alu_page3  out  4/1/1/1  captured opcode fields to the ALU.
REQ-016 alu_out  in  16; alu_c, alu_z, alu_n, alu_v  in  1 each  combinational ALU results.
REQ-017 reg_we  out  1  one-cycle strobe: write result to destination register.
REQ-018 result  out  16  value for reg_we, held until next EXEC.
REQ-019 cc_we  out  1  one-cycle strobe: latch alu flags into CC.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse at operation end.
REQ-022 err  out  1  one-cycle pulse coincident with done for an undecodable op.

Function
REQ-023 Op classes SHALL be decoded from captured fields: LOAD = nibble C with op6 and no page, or nibble E; STORE = nibble D with op6, or nibble F; ARITH = nibble 3 (add/subd/cmpd/cmpu) or nibble C not LOAD (cmpx/cmpy/cmps); SEX = nibble D with ~op6; all else ILLEGAL.
REQ-024 States SHALL be IDLE, RD_HI, RD_LO, EXEC, WR_HI, WR_LO, DONE.
REQ-025 IDLE + start: LOAD/ARITH -> RD_HI; STORE/SEX -> EXEC; ILLEGAL -> DONE with err.
REQ-026 RD_HI -> RD_LO and RD_LO -> EXEC SHALL occur only on an edge where mem_ack is high; otherwise the state holds.
REQ-027 EXEC SHALL last exactly one cycle; then STORE -> WR_HI, all others -> DONE.
REQ-028 WR_HI -> WR_LO -> DONE SHALL each advance only on mem_ack.
REQ-029 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-030 Byte order SHALL be big-endian: high byte at ea, low byte at ea+1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-031 mem_req SHALL be high in RD_HI, RD_LO, WR_HI and WR_LO only; mem_addr, mem_we and mem_wdata SHALL remain stable until acked.
REQ-032 Read bytes SHALL be captured on ack into operand word B; alu_in_a = captured reg_in; alu_in_b = word B (zero for STORE/SEX).
REQ-033 In EXEC: cc_we = 1 for all classes; reg_we = 1 for LOAD, SEX, add and subd; reg_we = 0 for compares and STORE; result <= alu_out.
REQ-034 STORE write data SHALL be alu_out captured in EXEC: high byte in WR_HI, low byte in WR_LO.
REQ-035 mem_ack while mem_req is low SHALL be ignored; start while busy SHALL be ignored.
REQ-036 Minimum latency from the start edge to the done cycle, with mem_ack tied high, SHALL be: LOAD/ARITH 4 cycles, STORE 4, SEX 2, ILLEGAL 1.

Reset
REQ-037 On reset the state SHALL be IDLE, with mem_req, mem_we, reg_we, cc_we, done, err and busy at 0; result, mem_addr, mem_wdata, alu_in_a and alu_in_b SHALL be 0x0000/0x00.
REQ-038 Reset SHALL take effect in any state, abandoning the transfer in flight; no reg_we or cc_we SHALL follow.

Verification
REQ-039 LOAD (op=E, op6=0, page2=0), ea=0x1000, memory 0x12,0x34, ack tied high -> reads at 0x1000 then 0x1001; EXEC reg_we=1, result=0x1234, cc_we=1; done in cycle 4.
REQ-040 STORE (op=F, op6=0), reg_in=0xBEEF, ea=0xFFFF -> writes 0xBE at 0xFFFF, then 0xEF at 0x0000; reg_we never set.
REQ-041 CMP (op=C, op6=0, no page), mem_ack delayed 3 cycles per byte -> mem_req and mem_addr held stable; cc_we=1 and reg_we=0; done in cycle 10.
REQ-042 SEX (op=D, op6=0) -> no mem_req; EXEC in cycle 1; done in cycle 2.
REQ-043 Illegal nibble 0x5 -> done=1 and err=1 in the same cycle, one cycle after start; no strobes.
REQ-044 Reset asserted in RD_LO, and start pulsed while busy -> IDLE with all outputs zero on the next edge; the mid-op start is ignored.

Source files
------------

// File: rtl/m6809_core_wordseq.sv
// 16-bit operand sequencer for the 6809 core: moves big-endian words over the
// byte bus around a single ALU evaluation (loads, stores, 16-bit arith, SEX).
//
// state | meaning
// IDLE  | waiting for start; operands captured on accepted start
// RD_HI | reading operand high byte at ea
// RD_LO | reading operand low byte at ea+1
// EXEC  | ALU result valid; strobe cc_we and (if writing back) reg_we
// WR_HI | writing result high byte at ea
// WR_LO | writing result low byte at ea+1
// DONE  | one-cycle done pulse, with err for an undecodable op
module m6809_core_wordseq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        op6,
  input  logic        page2,
  input  logic        page3,
  input  logic [15:0] ea,
  input  logic [15:0] reg_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] alu_in_a,
  output logic [15:0] alu_in_b,
  output logic [3:0]  alu_op,
  output logic        alu_op6,
  output logic        alu_page2,
  output logic        alu_page3,
  input  logic [15:0] alu_out,
  input  logic        alu_c,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  output logic        reg_we,
  output logic [15:0] result,
  output logic        cc_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HI,
    S_RD_LO,
    S_EXEC,
    S_WR_HI,
    S_WR_LO,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    CL_LOAD,
    CL_STORE,
    CL_ARITH,
    CL_SEX,
    CL_ILLEGAL
  } op_class_e;

  function automatic op_class_e decode(input logic [3:0] nib, input logic o6,
                                       input logic p2, input logic p3);
    logic no_page;
    no_page = !p2 && !p3;
    if ((nib == 4'hC && o6 && no_page) || nib == 4'hE)
      return CL_LOAD;
    else if ((nib == 4'hD && o6) || nib == 4'hF)
      return CL_STORE;
    else if (nib == 4'h3 || nib == 4'hC)
      return CL_ARITH;
    else if (nib == 4'hD)
      return CL_SEX;
    return CL_ILLEGAL;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic        op6_q, page2_q, page3_q;
  logic [15:0] ea_q, ea_nxt;
  logic [15:0] a_q, b_q;
  logic [15:0] result_q;
  op_class_e   start_cls, cur_cls;
  logic        wb_en;

  // Flags are latched into CC outside this block; only the strobe lives here.
  logic unused_alu_flags;
  assign unused_alu_flags = ^{alu_c, alu_z, alu_n, alu_v};

  assign start_cls = decode(op, op6, page2, page3);
  assign cur_cls   = decode(op_q, op6_q, page2_q, page3_q);
  assign ea_nxt    = ea_q + 16'd1;

  // Compares (nibble C arith, or nibble 3 on page 2/3) only update CC.
  assign wb_en = (cur_cls == CL_LOAD) || (cur_cls == CL_SEX) ||
                 (cur_cls == CL_ARITH && op_q == 4'h3 && !page2_q && !page3_q);

  assign alu_in_a  = a_q;
  assign alu_in_b  = b_q;
  assign alu_op    = op_q;
  assign alu_op6   = op6_q;
  assign alu_page2 = page2_q;
  assign alu_page3 = page3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 4'h0;
      op6_q    <= 1'b0;
      page2_q  <= 1'b0;
      page3_q  <= 1'b0;
      ea_q     <= 16'h0000;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q    <= op;
        op6_q   <= op6;
        page2_q <= page2;
        page3_q <= page3;
        ea_q    <= ea;
        a_q     <= reg_in;
        b_q     <= 16'h0000;
      end
      if (state_q == S_RD_HI && mem_ack)
        b_q[15:8] <= mem_rdata;
      if (state_q == S_RD_LO && mem_ack)
        b_q[7:0] <= mem_rdata;
      if (state_q == S_EXEC)
        result_q <= alu_out;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    reg_we    = 1'b0;
    cc_we     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state_q != S_IDLE);
    // During EXEC the live ALU output accompanies reg_we; afterwards it is held.
    result    = (state_q == S_EXEC) ? alu_out : result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (start_cls)
            CL_LOAD, CL_ARITH: state_d = S_RD_HI;
            CL_STORE, CL_SEX:  state_d = S_EXEC;
            default:           state_d = S_DONE;
          endcase
        end
      end
      S_RD_HI: begin
        mem_req  = 1'b1;
        mem_addr = ea_q;
        if (mem_ack)
          state_d = S_RD_LO;
      end
      S_RD_LO: begin
        mem_req  = 1'b1;
        mem_addr = ea_nxt;
        if (mem_ack)
          state_d = S_EXEC;
      end
      S_EXEC: begin
        cc_we   = 1'b1;
        reg_we  = wb_en;
        state_d = (cur_cls == CL_STORE) ? S_WR_HI : S_DONE;
      end
      S_WR_HI: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ea_q;
        mem_wdata = result_q[15:8];
        if (mem_ack)
          state_d = S_WR_LO;
      end
      S_WR_LO: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ea_nxt;
        mem_wdata = result_q[7:0];
        if (mem_ack)
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = (cur_cls == CL_ILLEGAL);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
